sram_phase_sequencer: RTL

Top-level sequencer that owns the single external SRAM port and hands it, one phase at a time, to the UART loader, the decoder stages (M2 then M1) and the VGA reader. It starts the UART→SRAM transfer on a user Start edge, detects end-of-file by write inactivity, launches M2 and M1 in order with start/done handshakes, then enables display. All SRAM bus muxing happens here; no requester drives the SRAM pins directly.

---
 rtl/sram_phase_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_phase_sequencer.sv
// -----------------------------------------------------------------------------
// sram_phase_sequencer
//
// Owns the single external SRAM port. It hands the port to one requester at a
// time, in the order UART loader -> M2 decoder -> M1 decoder -> VGA reader.
//
//   Start (rising edge, accepted in idle/display)
//     -> S_UART_INIT : one-cycle UART_initialize
//     -> S_UART_LOAD : UART_enable high; loader owns SRAM. The phase ends when
//                      the write-inactivity timeout expires or the loader
//                      parks on the last SRAM word.
//     -> S_M2_RUN    : M2_start pulse; M2 owns SRAM until M2_done
//     -> S_M1_RUN    : M1_start pulse; M1 owns SRAM until M1_done
//     -> S_DISPLAY   : VGA_enable high; VGA read address drives SRAM
//
// Ports
//   Clock, Resetn            : 50 MHz clock, asynchronous active-low reset
//   Start                    : user request, rising-edge detected here
//   UART_initialize/_enable  : loader control (pulse / level)
//   UART_SRAM_*              : loader bus request (address, data, we_n)
//   M2_start/M2_done, M2_SRAM_* : M2 handshake and bus request
//   M1_start/M1_done, M1_SRAM_* : M1 handshake and bus request
//   VGA_enable, VGA_SRAM_address : display control and read address
//   SRAM_address/_write_data/_we_n : muxed SRAM pins
//   Phase, Busy              : 0 idle, 1 load, 2 M2, 3 M1, 4 display; Busy in 1..3
//
// Parameters
//   TIMEOUT_CYCLES : idle cycles after the last loader write that mark end of
//                    file (>= 2)
//   TIMEOUT_W      : idle counter width; must hold TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module sram_phase_sequencer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMEOUT_W      = 26
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,

  output logic        UART_initialize,
  output logic        UART_enable,
  input  logic [17:0] UART_SRAM_address,
  input  logic [15:0] UART_SRAM_write_data,
  input  logic        UART_SRAM_we_n,

  output logic        M2_start,
  input  logic        M2_done,
  input  logic [17:0] M2_SRAM_address,
  input  logic [15:0] M2_SRAM_write_data,
  input  logic        M2_SRAM_we_n,

  output logic        M1_start,
  input  logic        M1_done,
  input  logic [17:0] M1_SRAM_address,
  input  logic [15:0] M1_SRAM_write_data,
  input  logic        M1_SRAM_we_n,

  output logic        VGA_enable,
  input  logic [17:0] VGA_SRAM_address,

  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,

  output logic [2:0]  Phase,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UART_INIT,
    S_UART_LOAD,
    S_M2_RUN,
    S_M1_RUN,
    S_DISPLAY
  } state_t;

  localparam logic [17:0]          LAST_ADDRESS = 18'h3FFFF;
  localparam logic [TIMEOUT_W-1:0] IDLE_MAX     = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state;
  state_t               state_next;

  logic                 start_d;
  logic                 start_edge;

  logic                 first_write;
  logic [TIMEOUT_W-1:0] idle_cnt;
  logic [TIMEOUT_W-1:0] idle_cnt_inc;
  logic                 timeout_hit;
  logic                 sram_full;
  logic                 load_done;
  logic                 m2_finished;
  logic                 m1_finished;

  // ---------------------------------------------------------------------------
  // Start edge detector. The edge itself is registered so that the request
  // reaches the state register one cycle later: Start first high in cycle n
  // gives UART_initialize in cycle n+2.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_d    <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      start_d    <= Start;
      start_edge <= Start & ~start_d;
    end
  end

  // ---------------------------------------------------------------------------
  // End-of-file detection during the load phase.
  // The counter is held at zero until the first write and on every write, then
  // counts idle cycles. The exit fires when the saturating increment lands on
  // TIMEOUT_CYCLES-1, so the last write in cycle w leads to M2_start in cycle
  // w+TIMEOUT_CYCLES (one cycle for the state change, one for the start flop
  // being the first cycle of S_M2_RUN).
  // ---------------------------------------------------------------------------
  assign idle_cnt_inc = (idle_cnt == IDLE_MAX) ? IDLE_MAX
                                               : idle_cnt + TIMEOUT_W'(1);

  assign timeout_hit = (state == S_UART_LOAD) && first_write &&
                       UART_SRAM_we_n && (idle_cnt_inc == IDLE_MAX);

  // Loader parked on the last word without writing: SRAM is full.
  assign sram_full   = (state == S_UART_LOAD) && first_write &&
                       UART_SRAM_we_n && (UART_SRAM_address == LAST_ADDRESS);

  assign load_done   = timeout_hit | sram_full;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      first_write <= 1'b0;
      idle_cnt    <= '0;
    end else if (state != S_UART_LOAD) begin
      first_write <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      if (!UART_SRAM_we_n) begin
        first_write <= 1'b1;
      end
      if (!UART_SRAM_we_n || !first_write) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt_inc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Done qualification. A done seen in the same cycle as the matching start
  // pulse is stale (left over from a previous run) and is ignored.
  // ---------------------------------------------------------------------------
  assign m2_finished = (state == S_M2_RUN) && M2_done && !M2_start;
  assign m1_finished = (state == S_M1_RUN) && M1_done && !M1_start;

  // ---------------------------------------------------------------------------
  // State register and one-cycle start pulses. The pulses are flops set on
  // the transition, so each one is high exactly in the first cycle of the
  // phase it launches.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      M2_start <= 1'b0;
      M1_start <= 1'b0;
    end else begin
      state    <= state_next;
      M2_start <= load_done;
      M1_start <= m2_finished;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start_edge) state_next = S_UART_INIT;
      end
      S_UART_INIT: begin
        state_next = S_UART_LOAD;
      end
      S_UART_LOAD: begin
        if (load_done) state_next = S_M2_RUN;
      end
      S_M2_RUN: begin
        if (m2_finished) state_next = S_M1_RUN;
      end
      S_M1_RUN: begin
        if (m1_finished) state_next = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (start_edge) state_next = S_UART_INIT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Level outputs decoded from the current state. Because they depend only on
  // the state register, an asynchronous reset drops them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    UART_initialize = (state == S_UART_INIT);
    UART_enable     = (state == S_UART_LOAD);
    VGA_enable      = (state == S_DISPLAY);
    Phase           = 3'd0;
    unique case (state)
      S_IDLE:      Phase = 3'd0;
      S_UART_INIT: Phase = 3'd1;
      S_UART_LOAD: Phase = 3'd1;
      S_M2_RUN:    Phase = 3'd2;
      S_M1_RUN:    Phase = 3'd3;
      S_DISPLAY:   Phase = 3'd4;
      default:     Phase = 3'd0;
    endcase
    Busy = (state == S_UART_INIT) || (state == S_UART_LOAD) ||
           (state == S_M2_RUN)    || (state == S_M1_RUN);
  end

  // ---------------------------------------------------------------------------
  // SRAM bus mux. Ownership follows the state register with no dead cycle;
  // only the current owner's we_n can reach the pin, and every other state
  // forces a read (we_n = 1), which also abandons a write on reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    unique case (state)
      S_UART_LOAD: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_M2_RUN: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      S_M1_RUN: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      S_DISPLAY: begin
        SRAM_address    = VGA_SRAM_address;
      end
      default: begin
        SRAM_address    = 18'd0;
      end
    endcase
  end

endmodule
